imm_ext_stage: RTL and testbench
================================

Name: imm_ext_stage

Overview:
- Pipelined, parametrised immediate extender for the decode/execute boundary of the processor.
- Widens an IN_W-bit immediate to OUT_W bits in one of four modes: sign, zero, upper, branch-offset.
- Carries a tag (destination register index) alongside each immediate.
- Registered output with valid/ready handshake, a 2-entry skid buffer so in_ready is a flop, and a synchronous flush for branch mispredicts.

Parameters:
IN_W, 17, immediate input width; must be 2..OUT_W-1
OUT_W, 32, extended output width
BR_SHIFT, 2, left shift applied in branch mode; must be <= OUT_W-IN_W
TAG_W, 5, width of sideband tag carried with each immediate

Ports:
clock  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-low reset
flush  input  1  synchronous discard of all buffered entries
in_valid  input  1  input entry valid
in_ready  output  1  stage can accept an entry this cycle
in_imm  input  IN_W  raw immediate field
in_mode  input  2  0=SIGN, 1=ZERO, 2=UPPER, 3=BRANCH
in_tag  input  TAG_W  sideband tag
out_valid  output  1  output entry valid
out_ready  input  1  downstream accepts output this cycle
out_imm  output  OUT_W  extended immediate
out_tag  output  TAG_W  tag of the output entry
out_mode  output  2  mode used for the output entry

Behaviour:
- Extension, all combinational on the input, result registered:
  - SIGN: bits [IN_W-1:0]=imm; upper bits = imm[IN_W-1].
  - ZERO: upper bits = 0.
  - UPPER: imm placed at [OUT_W-1:OUT_W-IN_W]; low bits = 0.
  - BRANCH: SIGN result shifted left by BR_SHIFT, zero-filled. No overflow is possible under the parameter constraint.
- Handshake:
  - Input transfer occurs when in_valid & in_ready.
  - Output transfer occurs when out_valid & out_ready.
  - out_imm, out_tag and out_mode are stable while out_valid=1 and out_ready=0.
- Latency: an accepted entry appears on out_* in the next cycle if the output register is empty or drains that same cycle. Throughput is 1 entry/cycle.
- State machine (occupancy):
  - EMPTY: out_valid=0, in_ready=1.
    - Accept -> ONE.
  - ONE: output register full, skid empty, in_ready=1.
    - Accept & drain -> ONE; the output register takes the new entry.
    - Accept & no drain -> TWO; the new entry goes to skid.
    - Drain & no accept -> EMPTY.
    - Otherwise stay in ONE.
  - TWO: output register full, skid full, in_ready=0.
    - Drain -> ONE; the skid entry moves to the output register.
    - Otherwise stay in TWO.
- in_ready is a registered function of state: 1 in EMPTY and ONE, 0 in TWO. Entries leave in acceptance order.
- flush=1: next state is EMPTY. Any entry offered in the same cycle is dropped, even if in_ready=1. The downstream transfer in the flush cycle still counts as completed.
- reset=0, sampled at the clock edge, has priority over flush:
  - State -> EMPTY, out_valid=0, in_ready=1.
  - out_imm=0, out_tag=0, out_mode=0; skid contents = 0.
- Reset mid-operation discards both entries with no partial output.
- in_* values are ignored when in_valid=0. Datapath registers load only on transfer.

Decomposition:
- Package imm_ext_pkg holds:
  - mode constants MODE_SIGN=2'd0, MODE_ZERO=2'd1, MODE_UPPER=2'd2, MODE_BRANCH=2'd3;
  - occupancy state encoding ST_EMPTY, ST_ONE, ST_TWO.
- One combinational sub-module, imm_ext_core (IN_W, OUT_W, BR_SHIFT): mode + imm -> extended value. The top level instantiates it once on the input path. The top holds the FSM, output register and skid register.

Test Plan:
- Modes, defaults, out_ready=1, one entry per mode with imm=17'h1FFFF:
  - SIGN -> 32'hFFFFFFFF; ZERO -> 32'h0001FFFF; UPPER -> 32'hFFFF8000; BRANCH -> 32'hFFFFFFFC.
  - Each appears 1 cycle after acceptance.
- Positive branch: imm=17'h00003, mode BRANCH -> 32'h0000000C. imm=17'h10000, mode BRANCH -> 32'hFFFC0000.
- Backpressure:
  - Hold out_ready=0 and stream tags 1,2,3 -> in_ready falls after 2 accepts; tag 3 is held off; out_tag=1 stays stable.
  - Then raise out_ready -> out_tag sequence 1,2,3 with no loss or duplication.
- Full throughput: 20 back-to-back entries with out_ready=1 -> 20 outputs on consecutive cycles, in_ready constantly 1.
- Flush in TWO with in_valid=1 -> next cycle out_valid=0, in_ready=1. The next accepted entry (tag 7) is the only one emitted.
- Reset: assert reset=0 for 1 cycle while in TWO -> all outputs 0, out_valid=0, in_ready=1. Deassert -> normal operation resumes on the next accept.

Source files
------------

// File: rtl/imm_ext_pkg.sv
// Shared constants for the immediate extender stage: mode codes and occupancy states.
package imm_ext_pkg;

  localparam logic [1:0] MODE_SIGN   = 2'd0;
  localparam logic [1:0] MODE_ZERO   = 2'd1;
  localparam logic [1:0] MODE_UPPER  = 2'd2;
  localparam logic [1:0] MODE_BRANCH = 2'd3;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_TWO   = 2'd2;

endpackage

// File: rtl/imm_ext_core.sv
// Combinational immediate widener: sign, zero, upper-placed or scaled branch offset.
module imm_ext_core
  import imm_ext_pkg::*;
#(
  parameter int IN_W     = 17,
  parameter int OUT_W    = 32,
  parameter int BR_SHIFT = 2
) (
  input  logic [IN_W-1:0]  imm,
  input  logic [1:0]       mode,
  output logic [OUT_W-1:0] ext
);

  logic [OUT_W-1:0] sign_ext;
  logic [OUT_W-1:0] zero_ext;
  logic [OUT_W-1:0] upper_ext;
  logic [OUT_W-1:0] branch_ext;

  assign sign_ext   = {{(OUT_W-IN_W){imm[IN_W-1]}}, imm};
  assign zero_ext   = {{(OUT_W-IN_W){1'b0}}, imm};
  assign upper_ext  = {imm, {(OUT_W-IN_W){1'b0}}};
  // BR_SHIFT <= OUT_W-IN_W, so the shifted-out bits are all sign copies
  assign branch_ext = sign_ext << BR_SHIFT;

  always_comb begin
    ext = sign_ext;
    case (mode)
      MODE_SIGN:   ext = sign_ext;
      MODE_ZERO:   ext = zero_ext;
      MODE_UPPER:  ext = upper_ext;
      MODE_BRANCH: ext = branch_ext;
      default:     ext = sign_ext;
    endcase
  end

endmodule

// File: rtl/imm_ext_stage.sv
// Registered immediate extender with a 2-entry skid so in_ready comes straight from a flop.
//   state    | meaning
//   ST_EMPTY | nothing held, out_valid=0, in_ready=1
//   ST_ONE   | output register full, skid empty, in_ready=1
//   ST_TWO   | output register and skid full, in_ready=0
module imm_ext_stage
  import imm_ext_pkg::*;
#(
  parameter int IN_W     = 17,
  parameter int OUT_W    = 32,
  parameter int BR_SHIFT = 2,
  parameter int TAG_W    = 5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IN_W-1:0]   in_imm,
  input  logic [1:0]        in_mode,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_imm,
  output logic [TAG_W-1:0]  out_tag,
  output logic [1:0]        out_mode
);

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [OUT_W-1:0] ext_imm;
  logic [OUT_W-1:0] skid_imm;
  logic [TAG_W-1:0] skid_tag;
  logic [1:0]       skid_mode;
  logic             accept;
  logic             drain;

  imm_ext_core #(
    .IN_W    (IN_W),
    .OUT_W   (OUT_W),
    .BR_SHIFT(BR_SHIFT)
  ) u_core (
    .imm (in_imm),
    .mode(in_mode),
    .ext (ext_imm)
  );

  // an entry offered during flush is dropped even while in_ready=1
  assign accept = in_valid & in_ready & ~flush;
  assign drain  = out_valid & out_ready;

  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = ST_EMPTY;
    end else begin
      case (state)
        ST_EMPTY: if (accept) state_nxt = ST_ONE;
        ST_ONE: begin
          if (accept && !drain)      state_nxt = ST_TWO;
          else if (!accept && drain) state_nxt = ST_EMPTY;
        end
        ST_TWO:   if (drain) state_nxt = ST_ONE;
        default:  state_nxt = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= ST_EMPTY;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_imm   <= '0;
      out_tag   <= '0;
      out_mode  <= '0;
      skid_imm  <= '0;
      skid_tag  <= '0;
      skid_mode <= '0;
    end else begin
      state     <= state_nxt;
      in_ready  <= (state_nxt != ST_TWO);
      out_valid <= (state_nxt != ST_EMPTY);
      case (state)
        ST_EMPTY: begin
          if (accept) begin
            out_imm  <= ext_imm;
            out_tag  <= in_tag;
            out_mode <= in_mode;
          end
        end
        ST_ONE: begin
          if (accept && drain) begin
            out_imm  <= ext_imm;
            out_tag  <= in_tag;
            out_mode <= in_mode;
          end else if (accept) begin
            skid_imm  <= ext_imm;
            skid_tag  <= in_tag;
            skid_mode <= in_mode;
          end
        end
        ST_TWO: begin
          if (drain) begin
            out_imm  <= skid_imm;
            out_tag  <= skid_tag;
            out_mode <= skid_mode;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imm_ext_stage.sv
// Self-checking bench: directed scenarios plus random traffic against a queue-based reference.
module tb_imm_ext_stage;

  localparam int IN_W     = 17;
  localparam int OUT_W    = 32;
  localparam int BR_SHIFT = 2;
  localparam int TAG_W    = 5;

  logic              clock = 1'b0;
  logic              reset;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [IN_W-1:0]   in_imm;
  logic [1:0]        in_mode;
  logic [TAG_W-1:0]  in_tag;
  logic              out_valid;
  logic              out_ready;
  logic [OUT_W-1:0]  out_imm;
  logic [TAG_W-1:0]  out_tag;
  logic [1:0]        out_mode;

  typedef struct {
    logic [31:0]      imm;
    logic [TAG_W-1:0] tag;
    logic [1:0]       mode;
  } entry_t;

  entry_t exp_q[$];
  int     checks = 0;
  int     errors = 0;
  int     drained = 0;
  bit     zeros_expected = 1'b0;

  imm_ext_stage #(
    .IN_W(IN_W), .OUT_W(OUT_W), .BR_SHIFT(BR_SHIFT), .TAG_W(TAG_W)
  ) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_imm(in_imm),
    .in_mode(in_mode), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm),
    .out_tag(out_tag), .out_mode(out_mode)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference extension computed as integer arithmetic, reduced modulo 2^32
  function automatic logic [31:0] ref_ext(input logic [IN_W-1:0] imm, input logic [1:0] mode);
    longint u = longint'(imm);
    longint s = (u >= (64'sd1 <<< (IN_W-1))) ? u - (64'sd1 <<< IN_W) : u;
    longint r;
    case (mode)
      2'd0:    r = s;
      2'd1:    r = u;
      2'd2:    r = u * (64'sd1 <<< (OUT_W-IN_W));
      default: r = s * (64'sd1 <<< BR_SHIFT);
    endcase
    return r[31:0];
  endfunction

  task automatic check_outputs();
    check_eq("out_valid", out_valid, exp_q.size() > 0);
    check_eq("in_ready", in_ready, exp_q.size() < 2);
    if (exp_q.size() > 0) begin
      check_eq("out_imm", out_imm, exp_q[0].imm);
      check_eq("out_tag", out_tag, exp_q[0].tag);
      check_eq("out_mode", out_mode, exp_q[0].mode);
    end else if (zeros_expected) begin
      check_eq("rst_imm", out_imm, 0);
      check_eq("rst_tag", out_tag, 0);
      check_eq("rst_mode", out_mode, 0);
    end
  endtask

  // Called at a falling edge: drive, predict the rising edge, then check at the next falling edge
  task automatic step(input logic v, input logic [IN_W-1:0] imm, input logic [1:0] mode,
                      input logic [TAG_W-1:0] tag, input logic ordy, input logic fl, input logic rst_n);
    entry_t e;
    bit acc, drn;
    in_valid = v; in_imm = imm; in_mode = mode; in_tag = tag;
    out_ready = ordy; flush = fl; reset = rst_n;
    #1;
    if (!rst_n) begin
      exp_q.delete();
      zeros_expected = 1'b1;
    end else begin
      acc = v && (exp_q.size() < 2) && !fl;
      drn = ordy && (exp_q.size() > 0);
      if (drn) begin
        void'(exp_q.pop_front());
        drained++;
      end
      if (fl) exp_q.delete();
      if (acc) begin
        e.imm = ref_ext(imm, mode);
        e.tag = tag;
        e.mode = mode;
        exp_q.push_back(e);
        zeros_expected = 1'b0;
      end
    end
    @(negedge clock);
    check_outputs();
  endtask

  initial begin
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; in_imm = '0; in_mode = '0; in_tag = '0; out_ready = 1'b0;
    @(negedge clock);
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    check_eq("reset_in_ready", in_ready, 1);
    check_eq("reset_out_imm", out_imm, 0);

    // one entry per mode with an all-ones immediate
    step(1, 17'h1FFFF, 2'd0, 5'd1, 1, 0, 1);
    check_eq("sign_all1", out_imm, 32'hFFFFFFFF);
    step(1, 17'h1FFFF, 2'd1, 5'd2, 1, 0, 1);
    check_eq("zero_all1", out_imm, 32'h0001FFFF);
    step(1, 17'h1FFFF, 2'd2, 5'd3, 1, 0, 1);
    check_eq("upper_all1", out_imm, 32'hFFFF8000);
    step(1, 17'h1FFFF, 2'd3, 5'd4, 1, 0, 1);
    check_eq("branch_all1", out_imm, 32'hFFFFFFFC);
    step(1, 17'h00003, 2'd3, 5'd5, 1, 0, 1);
    check_eq("branch_pos", out_imm, 32'h0000000C);
    step(1, 17'h10000, 2'd3, 5'd6, 1, 0, 1);
    check_eq("branch_minneg", out_imm, 32'hFFFC0000);
    step(0, 0, 0, 0, 1, 0, 1);

    // backpressure: tag 3 is held off until the skid frees up
    step(1, 17'h00011, 2'd0, 5'd1, 0, 0, 1);
    step(1, 17'h00022, 2'd1, 5'd2, 0, 0, 1);
    check_eq("bp_in_ready_low", in_ready, 0);
    step(1, 17'h00033, 2'd2, 5'd3, 0, 0, 1);
    check_eq("bp_tag_stable", out_tag, 1);
    step(1, 17'h00033, 2'd2, 5'd3, 1, 0, 1);
    check_eq("bp_seq2", out_tag, 2);
    step(1, 17'h00033, 2'd2, 5'd3, 1, 0, 1);
    check_eq("bp_seq3", out_tag, 3);
    step(0, 0, 0, 0, 1, 0, 1);
    check_eq("bp_drained", out_valid, 0);

    // full throughput
    drained = 0;
    for (int i = 0; i < 20; i++) begin
      check_eq("tp_in_ready", in_ready, 1);
      step(1, IN_W'($urandom), 2'($urandom), TAG_W'(i), 1, 0, 1);
    end
    step(0, 0, 0, 0, 1, 0, 1);
    check_eq("tp_count", drained, 20);

    // flush while full with an offered entry
    step(1, 17'h00100, 2'd0, 5'd10, 0, 0, 1);
    step(1, 17'h00200, 2'd0, 5'd11, 0, 0, 1);
    step(1, 17'h00300, 2'd0, 5'd12, 0, 1, 1);
    check_eq("flush_valid", out_valid, 0);
    check_eq("flush_ready", in_ready, 1);
    step(1, 17'h00400, 2'd1, 5'd7, 0, 0, 1);
    check_eq("flush_tag7", out_tag, 7);
    step(0, 0, 0, 0, 1, 0, 1);
    check_eq("flush_only7", out_valid, 0);

    // reset while full
    step(1, 17'h00555, 2'd2, 5'd20, 0, 0, 1);
    step(1, 17'h00666, 2'd3, 5'd21, 0, 0, 1);
    step(1, 17'h00777, 2'd1, 5'd22, 1, 1, 0);
    check_eq("mid_rst_imm", out_imm, 0);
    check_eq("mid_rst_valid", out_valid, 0);
    step(1, 17'h00123, 2'd1, 5'd9, 0, 0, 1);
    check_eq("post_rst_imm", out_imm, 32'h00000123);
    step(0, 0, 0, 0, 1, 0, 1);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 3) != 0, IN_W'($urandom), 2'($urandom), TAG_W'($urandom),
           $urandom_range(0, 2) != 0, $urandom_range(0, 40) == 0, $urandom_range(0, 100) != 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
